percept_mac: RTL
================

Name: percept_mac

Overview:
Parametrised successor to the single-input perceptron. Holds N weight/data word pairs in one serial load chain and runs an N-cycle signed multiply-accumulate, with optional accumulation across runs. Applies a selectable activation and loads the result into a separate serial result chain. Sits in the MLH compute array; load, result and daisy-chain outputs are bit-serial so instances cascade cheaply.

Parameters:
DW, 32, signed two's-complement width of each weight and data word
N, 4, inputs per neuron (N >= 1)
ACCW, 72, accumulator/result width; must be >= 2*DW + clog2(N) (elaboration check)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in  in  1  serial load bit, enters LSB of load chain
shift  in  1  shift load chain by one bit this cycle
out  out  1  MSB of load chain (daisy-chain output)
start  in  1  begin MAC run (IDLE only)
accumulate  in  1  sampled with start: 1 = keep acc, 0 = clear acc
act_mode  in  1  sampled with start: 0 = identity, 1 = ReLU
busy  out  1  high while MAC in progress
done  out  1  one-cycle pulse, result register valid
in_res  in  1  serial bit into LSB of result chain
shift_res  in  1  shift result chain by one bit this cycle
out_res  out  1  MSB of result chain

Behaviour:
- Reset: load chain, acc, result chain, index counter = 0; state IDLE; out, out_res, busy, done = 0.
- Load chain S, 2*N*DW bits. On shift: S <= {S[MSB-1:0], in}; out = S[MSB].
- Layout after 2*N*DW shifts, each word sent MSB first, in order w0..w(N-1) then d0..d(N-1): S = {w0,...,w(N-1),d0,...,d(N-1)}.
- Result chain R, ACCW bits. On shift_res: R <= {R[ACCW-2:0], in_res}; out_res = R[ACCW-1].
- FSM states:
  - IDLE: start=1 and shift=0 -> MAC. Latch act_mode; if accumulate=0, acc <= 0. Index k <= 0.
  - MAC: each cycle acc <= acc + sext(w_k * d_k) (signed DW x DW, one multiplier); k++. After N cycles -> DONE. On the final MAC edge, R <= act(acc_next).
  - DONE: one cycle, then -> IDLE.
- busy = (state == MAC); done = (state == DONE), registered.
- Latency: start sampled at edge E0; MAC edges E1..EN; done high in the cycle after EN, i.e. N+1 cycles after start is sampled.
- act: identity passes acc_next; ReLU outputs 0 when acc_next[ACCW-1] = 1, else acc_next.
- Arithmetic: accumulator wraps modulo 2^ACCW, with no saturation. ACCW sizing guarantees no wrap within a single run; wrap is possible only across accumulate runs.
- Collisions:
  - shift while busy is ignored; S is frozen during MAC.
  - start while not IDLE is ignored.
  - start and shift in the same IDLE cycle: shift wins, start is dropped.
  - R load on the final MAC edge beats shift_res on the same edge. shift_res is honoured in all other cycles, including during MAC.
- Reset mid-run: immediate return to IDLE, all state cleared, no done pulse.

Decomposition:
- Package percept_pkg holds:
  - state enum (IDLE, MAC, DONE)
  - act-mode constants ACT_LIN = 0, ACT_RELU = 1
  - clog2 function, used for counter width and the ACCW check
- One natural sub-module: percept_shreg (parametrised width; shift enable, parallel load with priority, serial in/out, async active-high reset). Instantiated for S (load unused) and for R.

Test Plan:
- Reset: assert rst mid-cycle -> out, out_res, busy, done = 0 immediately, without waiting for a clock edge.
- Basic MAC, mode 0: w = {1,2,3,4}, d = {10,20,30,40}, start -> busy 4 cycles, done at start+5, 72-bit shift_res readout = 300.
- Readout and mode check:
  - Shift the load chain out with 256 shifts of in=0 -> identical 256-bit word order.
  - Rerun the same load with act_mode=1 -> 300.
- Sign and ReLU: w = {-3,0,0,0}, d = {5,0,0,0}:
  - mode 0 -> R = 72-bit two's complement of -15.
  - mode 1 -> R = 0.
- Accumulate and extremes:
  - Basic case with accumulate=1 -> 600.
  - All w = d = -2^31, accumulate=0 -> R = 2^64, sign bit 0.
- Collisions and reset:
  - start during busy ignored; shift during busy leaves out unchanged; start+shift in the same cycle does not start.
  - rst at MAC cycle 2 -> no done, R = 0, a new start runs normally.

Source files
------------

// File: rtl/percept_pkg.sv
// Shared types and helpers for the percept_mac neuron.
package percept_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ACT_LIN  = 1'b0;
  localparam logic ACT_RELU = 1'b1;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/percept_mac_if.sv
// Control/serial bus of percept_mac. The controller drives master, the neuron is slave.
interface percept_mac_if;
  logic in;
  logic shift;
  logic out;
  logic start;
  logic accumulate;
  logic act_mode;
  logic busy;
  logic done;
  logic in_res;
  logic shift_res;
  logic out_res;

  modport master (
    output in, shift, start, accumulate, act_mode, in_res, shift_res,
    input  out, busy, done, out_res
  );

  modport slave (
    input  in, shift, start, accumulate, act_mode, in_res, shift_res,
    output out, busy, done, out_res
  );
endinterface

// File: rtl/percept_shreg.sv
// Serial shift register with a parallel load that takes priority over shifting.
module percept_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_sin,
  output logic         o_sout,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load wins over shift; new bits enter at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= '0;
    else if (i_ld) r_q <= i_ld_val;
    else if (i_en) r_q <= {r_q[W-2:0], i_sin};
  end

  assign o_q    = r_q;
  assign o_sout = r_q[W-1];

endmodule

// File: rtl/percept_mac.sv
// N-input signed MAC neuron: serial weight/data load, N-cycle accumulate,
// identity/ReLU activation into a serial result chain.
module percept_mac
  import percept_pkg::*;
#(
  parameter int DW   = 32,
  parameter int N    = 4,
  parameter int ACCW = 72
) (
  input logic          clk,
  input logic          rst,
  percept_mac_if.slave bus
);

  localparam int SW = 2 * N * DW;
  localparam int KW = (N > 1) ? clog2(N) : 1;

  if (N < 1) begin : g_n_chk
    $error("percept_mac: N must be >= 1");
  end
  if (ACCW < 2 * DW + clog2(N)) begin : g_accw_chk
    $error("percept_mac: ACCW too narrow for N products of DW x DW");
  end

  state_t                  r_state, w_state_nx;
  logic [KW-1:0]           r_k;
  logic signed [ACCW-1:0]  r_acc;
  logic                    r_act;

  logic [SW-1:0]           w_s_q;
  logic [ACCW-1:0]         w_unused_rq;
  logic signed [DW-1:0]    w_w [N];
  logic signed [DW-1:0]    w_d [N];
  logic signed [DW-1:0]    w_wk, w_dk;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACCW-1:0]  w_prod_x, w_acc_next;
  logic [ACCW-1:0]         w_r_ld_val;
  logic                    w_start_ok, w_last;

  // Chain layout is {w0..w(N-1), d0..d(N-1)} with w0 at the MSB end.
  for (genvar g = 0; g < N; g++) begin : g_words
    assign w_w[g] = w_s_q[(2*N-1-g)*DW +: DW];
    assign w_d[g] = w_s_q[(N-1-g)*DW +: DW];
  end

  // Load chain is frozen while the MAC reads it.
  percept_shreg #(.W(SW)) u_sreg (
    .clk      (clk),
    .rst      (rst),
    .i_en     (bus.shift && (r_state != MAC)),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .i_sin    (bus.in),
    .o_sout   (bus.out),
    .o_q      (w_s_q)
  );

  assign w_wk       = w_w[r_k];
  assign w_dk       = w_d[r_k];
  assign w_prod     = w_wk * w_dk;
  assign w_prod_x   = ACCW'(w_prod);
  assign w_acc_next = r_acc + w_prod_x;
  assign w_r_ld_val = (r_act == ACT_RELU && w_acc_next[ACCW-1]) ? '0 : w_acc_next;

  // A shift in the same IDLE cycle drops the start.
  assign w_start_ok = (r_state == IDLE) && bus.start && !bus.shift;
  assign w_last     = (r_state == MAC) && (r_k == KW'(N - 1));

  // Result chain takes the activated sum on the last MAC edge, else shifts.
  percept_shreg #(.W(ACCW)) u_rreg (
    .clk      (clk),
    .rst      (rst),
    .i_en     (bus.shift_res),
    .i_ld     (w_last),
    .i_ld_val (w_r_ld_val),
    .i_sin    (bus.in_res),
    .o_sout   (bus.out_res),
    .o_q      (w_unused_rq)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nx = MAC;
      MAC:     if (w_last)     w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Accumulator, product index and latched activation mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_k   <= '0;
      r_act <= ACT_LIN;
    end else if (w_start_ok) begin
      r_act <= bus.act_mode;
      r_k   <= '0;
      if (!bus.accumulate) r_acc <= '0;
    end else if (r_state == MAC) begin
      r_acc <= w_acc_next;
      r_k   <= r_k + 1'b1;
    end
  end

  assign bus.busy = (r_state == MAC);
  assign bus.done = (r_state == DONE);

endmodule
